// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot engine and its command deframer:
// fixed-point format, power-on parameter set, sync byte and receiver states.
package mandel_pkg;

    localparam int N_BIT    = 25;
    localparam int BIT_FRAC = 20;

    localparam logic [8:0]       PIX_X_RST    = 9'd510;
    localparam logic [7:0]       PIX_Y_RST    = 8'd255;
    localparam logic [N_BIT-1:0] CXS_RST      = 25'h1E00000;
    localparam logic [N_BIT-1:0] CYS_RST      = 25'h1F00000;
    localparam logic [N_BIT-1:0] DCX_RST      = 25'h0004000;
    localparam logic [N_BIT-1:0] DCY_RST      = 25'h0004000;
    localparam logic [15:0]      MAX_ITER_RST = 16'd100;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [8:0]       pix_x;
        logic [7:0]       pix_y;
        logic [N_BIT-1:0] cxs;
        logic [N_BIT-1:0] cys;
        logic [N_BIT-1:0] dcx;
        logic [N_BIT-1:0] dcy;
        logic [15:0]      max_iter;
    } mandel_params_t;

    localparam mandel_params_t PARAMS_RST = '{
        pix_x:    PIX_X_RST,
        pix_y:    PIX_Y_RST,
        cxs:      CXS_RST,
        cys:      CYS_RST,
        dcx:      DCX_RST,
        dcy:      DCY_RST,
        max_iter: MAX_ITER_RST
    };

    // Running XOR used for the optional packet checksum.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/mandel_cmd_rx_if.sv
// Command deframer bundle: UART byte/ready pair, engine handshake and the
// committed parameter set. slave = deframer side, master = host/engine side.
interface mandel_cmd_rx_if;
    import mandel_pkg::*;

    logic [7:0]       rx_data;
    logic             rx_ready;
    logic             engine_busy;
    logic             start;
    logic [8:0]       pix_x;
    logic [7:0]       pix_y;
    logic [N_BIT-1:0] cxs;
    logic [N_BIT-1:0] cys;
    logic [N_BIT-1:0] dcx;
    logic [N_BIT-1:0] dcy;
    logic [15:0]      max_iter;
    logic             pkt_err;
    logic             rx_busy;

    modport slave (
        input  rx_data, rx_ready, engine_busy,
        output start, pix_x, pix_y, cxs, cys, dcx, dcy, max_iter, pkt_err, rx_busy
    );

    modport master (
        output rx_data, rx_ready, engine_busy,
        input  start, pix_x, pix_y, cxs, cys, dcx, dcy, max_iter, pkt_err, rx_busy
    );

endinterface

// File: rtl/mandel_cmd_rx_byte_strobe.sv
// Turns the UART receiver's level-type ready into a single accept pulse per
// high period, presented together with the byte it qualifies.
module cmd_byte_strobe (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       accept,
    output logic [7:0] data
);

    logic rx_ready_r;

    // Delayed copy of rx_ready for rising-level detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready_r <= 1'b0;
        end else begin
            rx_ready_r <= rx_ready;
        end
    end

    assign accept = rx_ready & ~rx_ready_r;
    assign data   = rx_data;

endmodule

// File: rtl/mandel_cmd_rx.sv
// Command deframer: hunts SYNC, assembles the parameter packet into a shadow
// set and commits it with a start pulse once the engine is idle.
// Optional trailing XOR checksum byte when MANDEL_CMD_CHECKSUM_EN is defined.
module mandel_cmd_rx
    import mandel_pkg::*;
#(
    parameter int COORD_BYTES    = 4,
    parameter int TIMEOUT_CYCLES = 7000000
) (
    input  logic           clk,
    input  logic           rst,
    mandel_cmd_rx_if.slave bus
);

    localparam int PKT_LEN = 6 + 4 * COORD_BYTES;
    localparam int CW      = 8 * COORD_BYTES;
    localparam int CNT_W   = $clog2(PKT_LEN + 2);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int F_CYS   = 4 + COORD_BYTES;
    localparam int F_DCX   = 4 + 2 * COORD_BYTES;
    localparam int F_DCY   = 4 + 3 * COORD_BYTES;
    localparam int F_MI    = 4 + 4 * COORD_BYTES;
`ifdef MANDEL_CMD_CHECKSUM_EN
    localparam int LAST_IDX = PKT_LEN;
`else
    localparam int LAST_IDX = PKT_LEN - 1;
`endif

    logic           accept_s;
    logic [7:0]     byte_s;
    rx_state_t      state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [TMO_W-1:0] tmo_r, tmo_next_s;
    mandel_params_t shadow_r, shadow_next_s, shadow_upd_s;
    mandel_params_t params_r, commit_val_s;
    logic           start_r;
    logic           pkt_err_r;
    logic           rx_busy_r;
    logic           commit_s;
    logic           err_s;
    logic           done_s;
`ifdef MANDEL_CMD_CHECKSUM_EN
    logic [7:0]     xor_r, xor_next_s;
`endif

    cmd_byte_strobe u_strobe (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (bus.rx_data),
        .rx_ready (bus.rx_ready),
        .accept   (accept_s),
        .data     (byte_s)
    );

    // Narrow wire fields carry their sign in bit CW-1; wide ones are already truncated.
    function automatic logic [N_BIT-1:0] to_coord(input logic [N_BIT-1:0] v);
        logic [N_BIT-1:0] r;
        for (int i = 0; i < N_BIT; i++) begin
            int src;
            src  = (i < CW) ? i : CW - 1;
            r[i] = v[src];
        end
        return r;
    endfunction

    // Routes the accepted byte into the shadow field selected by its packet index.
    always_comb begin
        shadow_upd_s = shadow_r;
        if (cnt_r < CNT_W'(3)) begin
            shadow_upd_s.pix_x = {shadow_r.pix_x[0], byte_s};
        end else if (cnt_r == CNT_W'(3)) begin
            shadow_upd_s.pix_y = byte_s;
        end else if (cnt_r < CNT_W'(F_CYS)) begin
            shadow_upd_s.cxs = {shadow_r.cxs[N_BIT-9:0], byte_s};
        end else if (cnt_r < CNT_W'(F_DCX)) begin
            shadow_upd_s.cys = {shadow_r.cys[N_BIT-9:0], byte_s};
        end else if (cnt_r < CNT_W'(F_DCY)) begin
            shadow_upd_s.dcx = {shadow_r.dcx[N_BIT-9:0], byte_s};
        end else if (cnt_r < CNT_W'(F_MI)) begin
            shadow_upd_s.dcy = {shadow_r.dcy[N_BIT-9:0], byte_s};
        end else begin
            shadow_upd_s.max_iter = {shadow_r.max_iter[7:0], byte_s};
        end
    end

    // Next-state, byte counting, timeout and commit/error decisions.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        tmo_next_s    = tmo_r;
        shadow_next_s = shadow_r;
        commit_s      = 1'b0;
        err_s         = 1'b0;
        done_s        = 1'b0;
`ifdef MANDEL_CMD_CHECKSUM_EN
        xor_next_s    = xor_r;
`endif
        case (state_r)
            ST_IDLE: begin
                tmo_next_s = {TMO_W{1'b0}};
                if (accept_s && (byte_s == SYNC_BYTE)) begin
                    state_next_s = ST_RECV;
                    cnt_next_s   = CNT_W'(1);
`ifdef MANDEL_CMD_CHECKSUM_EN
                    xor_next_s   = SYNC_BYTE;
`endif
                end else begin
                    cnt_next_s = {CNT_W{1'b0}};
                end
            end
            ST_RECV: begin
                if (accept_s) begin
                    tmo_next_s = {TMO_W{1'b0}};
                    cnt_next_s = cnt_r + CNT_W'(1);
`ifdef MANDEL_CMD_CHECKSUM_EN
                    if (cnt_r == CNT_W'(LAST_IDX)) begin
                        if (byte_s == xor_r) begin
                            done_s = 1'b1;
                        end else begin
                            err_s        = 1'b1;
                            state_next_s = ST_IDLE;
                            cnt_next_s   = {CNT_W{1'b0}};
                        end
                    end else begin
                        shadow_next_s = shadow_upd_s;
                        xor_next_s    = xor_fold(xor_r, byte_s);
                    end
`else
                    shadow_next_s = shadow_upd_s;
                    if (cnt_r == CNT_W'(LAST_IDX)) begin
                        done_s = 1'b1;
                    end else begin
                        done_s = 1'b0;
                    end
`endif
                end else if (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_s        = 1'b1;
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                    tmo_next_s   = {TMO_W{1'b0}};
                end else begin
                    tmo_next_s = tmo_r + TMO_W'(1);
                end
                // A complete packet commits straight away if the engine is already idle.
                if (done_s) begin
                    if (!bus.engine_busy) begin
                        commit_s     = 1'b1;
                        state_next_s = ST_IDLE;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end else begin
                    commit_s = 1'b0;
                end
            end
            ST_HOLD: begin
                tmo_next_s = {TMO_W{1'b0}};
                if (!bus.engine_busy) begin
                    commit_s     = 1'b1;
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
                tmo_next_s   = {TMO_W{1'b0}};
            end
        endcase
    end

    // Final coordinate formatting of the set about to be committed.
    always_comb begin
        commit_val_s     = shadow_next_s;
        commit_val_s.cxs = to_coord(shadow_next_s.cxs);
        commit_val_s.cys = to_coord(shadow_next_s.cys);
        commit_val_s.dcx = to_coord(shadow_next_s.dcx);
        commit_val_s.dcy = to_coord(shadow_next_s.dcy);
    end

    // FSM state, counters and shadow parameter set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            tmo_r    <= {TMO_W{1'b0}};
            shadow_r <= PARAMS_RST;
`ifdef MANDEL_CMD_CHECKSUM_EN
            xor_r    <= 8'h00;
`endif
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            tmo_r    <= tmo_next_s;
            shadow_r <= shadow_next_s;
`ifdef MANDEL_CMD_CHECKSUM_EN
            xor_r    <= xor_next_s;
`endif
        end
    end

    // Output registers: parameters move only together with the start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            params_r  <= PARAMS_RST;
            start_r   <= 1'b0;
            pkt_err_r <= 1'b0;
            rx_busy_r <= 1'b0;
        end else begin
            if (commit_s) begin
                params_r <= commit_val_s;
            end else begin
                params_r <= params_r;
            end
            start_r   <= commit_s;
            pkt_err_r <= err_s;
            rx_busy_r <= (state_next_s != ST_IDLE);
        end
    end

    assign bus.start    = start_r;
    assign bus.pkt_err  = pkt_err_r;
    assign bus.rx_busy  = rx_busy_r;
    assign bus.pix_x    = params_r.pix_x;
    assign bus.pix_y    = params_r.pix_y;
    assign bus.cxs      = params_r.cxs;
    assign bus.cys      = params_r.cys;
    assign bus.dcx      = params_r.dcx;
    assign bus.dcy      = params_r.dcy;
    assign bus.max_iter = params_r.max_iter;

endmodule

// File: tb/tb_mandel_cmd_rx.sv
// Scoreboard bench for mandel_cmd_rx: directed packets queue expected start /
// pkt_err events; a negedge monitor pops and compares them.
module tb_mandel_cmd_rx;

    localparam int TMO = 1000;

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [8:0]  px;
        logic [7:0]  py;
        logic [24:0] cxs;
        logic [24:0] cys;
        logic [24:0] dcx;
        logic [24:0] dcy;
        logic [15:0] mi;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t cur_exp;
    exp_t nxt_exp;
    exp_t rst_exp;
    logic [7:0] pkt[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mandel_cmd_rx_if bus();

    mandel_cmd_rx #(
        .COORD_BYTES    (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, want);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, "_pix_x"},    32'(bus.pix_x),    32'(e.px));
        chk({tag, "_pix_y"},    32'(bus.pix_y),    32'(e.py));
        chk({tag, "_cxs"},      32'(bus.cxs),      32'(e.cxs));
        chk({tag, "_cys"},      32'(bus.cys),      32'(e.cys));
        chk({tag, "_dcx"},      32'(bus.dcx),      32'(e.dcx));
        chk({tag, "_dcy"},      32'(bus.dcy),      32'(e.dcy));
        chk({tag, "_max_iter"}, 32'(bus.max_iter), 32'(e.mi));
    endtask

    // Monitor: every start or pkt_err must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst == 1'b0 && (bus.start === 1'b1 || bus.pkt_err === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event start=%0b pkt_err=%0b cycle=%0d required=no_event",
                         bus.start, bus.pkt_err, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("event_is_err", 32'(bus.pkt_err), 32'(e.is_err));
                chk("event_is_start", 32'(bus.start), 32'(!e.is_err));
                chk("event_cycle", cyc, e.cyc);
                chk_outputs("event", e);
            end
        end
    end

    task automatic set_exp(input logic [8:0] px, input logic [7:0] py, input logic [24:0] cxs,
                           input logic [24:0] cys, input logic [24:0] dcx, input logic [24:0] dcy,
                           input logic [15:0] mi);
        nxt_exp.is_err = 1'b0;
        nxt_exp.cyc    = 0;
        nxt_exp.px     = px;
        nxt_exp.py     = py;
        nxt_exp.cxs    = cxs;
        nxt_exp.cys    = cys;
        nxt_exp.dcx    = dcx;
        nxt_exp.dcy    = dcy;
        nxt_exp.mi     = mi;
    endtask

    task automatic make_pkt(input logic [15:0] px, input logic [7:0] py, input logic [31:0] c0,
                            input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3,
                            input logic [15:0] mi);
        logic [31:0] w[4];
        w[0] = c0; w[1] = c1; w[2] = c2; w[3] = c3;
        pkt.delete();
        pkt.push_back(8'hA5);
        pkt.push_back(px[15:8]);
        pkt.push_back(px[7:0]);
        pkt.push_back(py);
        for (int k = 0; k < 4; k++) begin
            pkt.push_back(w[k][31:24]);
            pkt.push_back(w[k][23:16]);
            pkt.push_back(w[k][15:8]);
            pkt.push_back(w[k][7:0]);
        end
        pkt.push_back(mi[15:8]);
        pkt.push_back(mi[7:0]);
    endtask

    // push_kind: 0 none, 1 start next cycle, 2 pkt_err after timeout, 3 pkt_err next cycle.
    task automatic send_byte(input logic [7:0] b, input int push_kind);
        exp_t e;
        @(posedge clk);
        #1;
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        if (push_kind == 1) begin
            nxt_exp.is_err = 1'b0;
            nxt_exp.cyc    = cyc + 1;
            exp_q.push_back(nxt_exp);
            cur_exp = nxt_exp;
        end else if (push_kind == 2 || push_kind == 3) begin
            e        = cur_exp;
            e.is_err = 1'b1;
            e.cyc    = (push_kind == 2) ? cyc + TMO + 1 : cyc + 1;
            exp_q.push_back(e);
        end
        repeat (2) @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_pkt(input int push_kind);
        logic [7:0] wire_q[$];
        wire_q = pkt;
`ifdef MANDEL_CMD_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (pkt[k]) x = x ^ pkt[k];
            wire_q.push_back(x);
        end
`endif
        for (int i = 0; i < wire_q.size(); i++) begin
            send_byte(wire_q[i], (i == wire_q.size() - 1) ? push_kind : 0);
        end
    endtask

`ifdef MANDEL_CMD_CHECKSUM_EN
    task automatic send_pkt_badsum();
        logic [7:0] x;
        x = 8'h00;
        foreach (pkt[k]) x = x ^ pkt[k];
        foreach (pkt[k]) send_byte(pkt[k], 0);
        send_byte(x ^ 8'hFF, 3);
    endtask
`endif

    initial begin
        bus.rx_data     = 8'h00;
        bus.rx_ready    = 1'b0;
        bus.engine_busy = 1'b0;
        rst_exp = '{1'b0, 0, 9'd510, 8'd255, 25'h1E00000, 25'h1F00000,
                    25'h0004000, 25'h0004000, 16'd100};
        cur_exp = rst_exp;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state after a long idle stretch
        repeat (1000) @(posedge clk);
        #1;
        chk_outputs("reset", rst_exp);
        chk("reset_rx_busy", 32'(bus.rx_busy), 32'd0);

        // Packet with the engine idle: start one cycle after the last byte
        make_pkt(16'h01FD, 8'h7F, 32'hFFE00000, 32'hFFF00000, 32'h00002000, 32'h00002000, 16'h00C8);
        set_exp(9'd509, 8'd127, 25'h1E00000, 25'h1F00000, 25'h0002000, 25'h0002000, 16'd200);
        send_pkt(1);

        // Engine busy: parameters held until busy drops
        bus.engine_busy = 1'b1;
        make_pkt(16'h0123, 8'h40, 32'h00100000, 32'h01F80000, 32'h00000800, 32'h00001000, 16'h03E8);
        set_exp(9'd291, 8'd64, 25'h0100000, 25'h1F80000, 25'h0000800, 25'h0001000, 16'd1000);
        send_pkt(0);
        repeat (500) @(posedge clk);
        #1;
        chk_outputs("hold", cur_exp);
        chk("hold_rx_busy", 32'(bus.rx_busy), 32'd1);
        @(posedge clk);
        #1;
        bus.engine_busy = 1'b0;
        nxt_exp.cyc = cyc + 1;
        exp_q.push_back(nxt_exp);
        cur_exp = nxt_exp;
        repeat (5) @(posedge clk);

        // Garbage before sync, then a packet with extreme field values
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h12, 0);
        make_pkt(16'hFFFF, 8'h00, 32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 16'hFFFF);
        set_exp(9'd511, 8'd0, 25'h1FFFFFF, 25'h0000000, 25'h1FFFFFF, 25'h0000001, 16'd65535);
        send_pkt(1);

        // Truncated packet: pkt_err after the inter-byte timeout, outputs kept
        send_byte(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h11, 0);
        send_byte(8'h22, 2);
        repeat (TMO + 50) @(posedge clk);
        make_pkt(16'h01FD, 8'h7F, 32'hFFE00000, 32'hFFF00000, 32'h00002000, 32'h00002000, 16'h00C8);
        set_exp(9'd509, 8'd127, 25'h1E00000, 25'h1F00000, 25'h0002000, 25'h0002000, 16'd200);
        send_pkt(1);

        // Reset in the middle of a packet
        make_pkt(16'hFFFF, 8'h00, 32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 16'hFFFF);
        for (int i = 0; i < 4; i++) send_byte(pkt[i], 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cur_exp = rst_exp;
        chk_outputs("midrst", rst_exp);
        chk("midrst_rx_busy", 32'(bus.rx_busy), 32'd0);
        make_pkt(16'h0123, 8'h40, 32'h00100000, 32'h01F80000, 32'h00000800, 32'h00001000, 16'h03E8);
        set_exp(9'd291, 8'd64, 25'h0100000, 25'h1F80000, 25'h0000800, 25'h0001000, 16'd1000);
        send_pkt(1);

`ifdef MANDEL_CMD_CHECKSUM_EN
        // Correct checksum commits; a corrupted one errors and keeps outputs
        make_pkt(16'hFFFF, 8'h00, 32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 16'hFFFF);
        set_exp(9'd511, 8'd0, 25'h1FFFFFF, 25'h0000000, 25'h1FFFFFF, 25'h0000001, 16'd65535);
        send_pkt(1);
        make_pkt(16'h01FD, 8'h7F, 32'hFFE00000, 32'hFFF00000, 32'h00002000, 32'h00002000, 16'h00C8);
        send_pkt_badsum();
        repeat (5) @(posedge clk);
        #1;
        chk_outputs("badsum", cur_exp);
`endif

        repeat (20) @(posedge clk);
        chk("pending_events", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
